// File: rtl/adder_tree_var_pipe_if.sv
// Bundle of operand/result signals for the pipelined variable-lane adder tree.
// Flow control: a token moves only on cycles where i_en=1. Input is accepted when i_en=1 and the
// lane-valid pattern qualifies for the selected mode. o_valid qualifies o_data_bus, and both hold while i_en=0.
interface adder_tree_var_pipe_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_IN     = 8
);
  localparam int LEVELS    = $clog2(NUM_IN);
  localparam int OUT_WIDTH = DATA_WIDTH + LEVELS;

  logic [NUM_IN*DATA_WIDTH-1:0] i_data_bus;
  logic [NUM_IN-1:0]            i_valid;
  logic                         i_mode;
  logic                         i_en;
  logic [OUT_WIDTH-1:0]         o_data_bus;
  logic                         o_valid;
  logic [LEVELS:0]              o_inflight;

  modport master (
    output i_data_bus, i_valid, i_mode, i_en,
    input  o_data_bus, o_valid, o_inflight
  );

  modport slave (
    input  i_data_bus, i_valid, i_mode, i_en,
    output o_data_bus, o_valid, o_inflight
  );
endinterface

// File: rtl/adder_tree_var_pipe.sv
// Pipelined binary adder tree with strict/masked lane qualification and a global stall enable.
// Each level registers its partial sums one bit wider than the level before, so no stage can overflow.
module adder_tree_var_pipe #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_IN     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  adder_tree_var_pipe_if.slave  bus
);
  localparam int LEVELS    = $clog2(NUM_IN);
  localparam int OUT_WIDTH = DATA_WIDTH + LEVELS;

  logic                         accept;
  logic [NUM_IN*DATA_WIDTH-1:0] masked_data;
  logic [LEVELS-1:0]            vld_vec;
  logic [LEVELS:0]              inflight;

  // In strict mode every lane is valid when a token is taken, so masking always is harmless.
  always_comb begin
    accept = bus.i_en && (bus.i_mode ? (|bus.i_valid) : (&bus.i_valid));
    masked_data = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      masked_data[k*DATA_WIDTH +: DATA_WIDTH] =
        bus.i_valid[k] ? bus.i_data_bus[k*DATA_WIDTH +: DATA_WIDTH] : '0;
    end
  end

  for (genvar s = 0; s < LEVELS; s++) begin : stage
    localparam int N  = NUM_IN >> (s + 1);
    localparam int W  = DATA_WIDTH + s + 1;
    localparam int PW = W - 1;

    logic [2*N*PW-1:0] prev_sum;
    logic              prev_vld;
    logic [N*W-1:0]    sum_d;
    logic [N*W-1:0]    sum_q;
    logic              vld_q;

    if (s == 0) begin : g_first
      assign prev_sum = masked_data;
      assign prev_vld = accept;
    end else begin : g_rest
      assign prev_sum = stage[s-1].sum_q;
      assign prev_vld = stage[s-1].vld_q;
    end

    always_comb begin
      sum_d = '0;
      for (int i = 0; i < N; i++) begin
        sum_d[i*W +: W] = {1'b0, prev_sum[2*i*PW +: PW]} + {1'b0, prev_sum[(2*i+1)*PW +: PW]};
      end
    end

    // Bubbles carry zero data so the final stage reads all zeros whenever it is invalid.
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q <= 1'b0;
        sum_q <= '0;
      end else if (bus.i_en) begin
        vld_q <= prev_vld;
        sum_q <= prev_vld ? sum_d : '0;
      end
    end

    assign vld_vec[s] = vld_q;
  end

  always_comb begin
    inflight = '0;
    for (int s = 0; s < LEVELS; s++) begin
      inflight = inflight + (LEVELS+1)'(vld_vec[s]);
    end
  end

  assign bus.o_data_bus = OUT_WIDTH'(stage[LEVELS-1].sum_q);
  assign bus.o_valid    = vld_vec[LEVELS-1];
  assign bus.o_inflight = inflight;
endmodule

// File: doc/adder_tree_var_pipe.md
ADDER_TREE_VAR_PIPE -- requirements
Module: adder_tree_var_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, width of each unsigned input operand.
REQ-002 SHALL have parameter NUM_IN, default 8, number of operands; power of two, >= 2.
REQ-003 SHALL have derived localparam LEVELS = log2(NUM_IN), which is the tree depth and the pipeline latency.
REQ-004 SHALL have derived localparam OUT_WIDTH = DATA_WIDTH + LEVELS.
REQ-005 SHALL provide port clk, input, 1 bit: single clock, all state on its rising edge.
REQ-006 SHALL provide port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL provide port i_data_bus, input, NUM_IN*DATA_WIDTH bits: operand k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL provide port i_valid, input, NUM_IN bits: bit k qualifies operand k.
REQ-009 SHALL provide port i_mode, input, 1 bit: 0 = strict (all lanes required), 1 = masked (invalid lanes count as zero).
REQ-010 SHALL provide port i_en, input, 1 bit: pipeline advance enable; low stalls the pipeline.
REQ-011 SHALL provide port o_data_bus, output, OUT_WIDTH bits: registered sum.
REQ-012 SHALL provide port o_valid, output, 1 bit: qualifies o_data_bus.
REQ-013 SHALL provide port o_inflight, output, LEVELS+1 bits: number of valid tokens currently in the pipeline.

Function
REQ-014 SHALL accept an input token on a cycle with i_en=1 when (i_mode=0 and i_valid all ones) or (i_mode=1 and i_valid nonzero).
- No token is accepted otherwise.
REQ-015 SHALL, in masked mode, substitute zero for every operand whose i_valid bit is 0 before the first adder level.
REQ-016 SHALL implement a binary tree of LEVELS register stages.
- Stage s holds NUM_IN/2^(s+1) partial sums, each of width DATA_WIDTH+s+1.
- Each stage has one valid bit.
REQ-017 SHALL make each addition zero-extended and unsigned, so that no overflow or truncation can occur at any stage.
REQ-018 SHALL present the sum of an accepted token on o_data_bus with o_valid=1 exactly LEVELS enabled cycles after acceptance.
REQ-019 SHALL, when i_en=0, hold every stage register, every valid bit, o_data_bus, o_valid and o_inflight unchanged.
- An output held under stall may remain visible for multiple cycles; downstream logic qualifies it with its own enable.
REQ-020 SHALL, when i_en=1, advance every stage by one position every cycle, creating bubbles (valid=0) where no token was accepted.
REQ-021 SHALL drive o_data_bus to all zeros whenever the last-stage valid bit is 0; don't-care output values are not permitted.
REQ-022 SHALL sustain throughput of one token per enabled cycle with no bubbles inserted by the block.
REQ-023 SHALL make o_inflight equal the population count of the stage valid bits, including the output stage.
- Range: 0..LEVELS.
REQ-024 SHALL sample i_mode per token at acceptance.
- Changing i_mode while tokens are in flight does not alter their sums.

Reset
REQ-025 SHALL, on rst=1 at a rising clk edge, clear all stage valid bits, o_valid, o_data_bus and o_inflight to 0, regardless of i_en.
REQ-026 SHALL discard tokens in flight at reset; no token accepted in or before the reset cycle emerges.
REQ-027 SHALL give rst priority over token acceptance in the same cycle.
REQ-028 SHALL accept a new token on the first cycle after rst falls, with output LEVELS cycles later.

Verification (DATA_WIDTH=16, NUM_IN=4, LEVELS=2, OUT_WIDTH=18)
REQ-029 SHALL cover the strict, all-valid case.
- Stimulus: mode 0, operands {1,2,3,4}, valid 4'b1111, i_en=1.
- Required response: o_valid=1, o_data_bus=10, two cycles later.
REQ-030 SHALL cover maximum-value operands.
- Stimulus: mode 0, all operands 16'hFFFF.
- Required response: o_data_bus = 18'h3FFFC, with no wrap.
REQ-031 SHALL cover the strict-versus-masked distinction.
- Strict: mode 0, operands {5,6,7,8}, valid 4'b1011 -> no token accepted, o_valid stays 0, o_data_bus stays 0.
- Masked: the same stimulus in mode 1 -> o_data_bus = 5+6+8 = 19 after 2 cycles.
REQ-032 SHALL cover back-to-back tokens through a stall.
- Stimulus: tokens A (sum 10), B (sum 20), C (sum 30) on consecutive cycles, then i_en=0 for 3 cycles, then i_en=1.
- Required response: outputs 10, 20, 30 appear in order with no loss or duplication across the enabled cycles.
- Required response: o_inflight reads 2 during the stall.
REQ-033 SHALL cover reset mid-flight.
- Stimulus: 2 tokens in flight, assert rst for 1 cycle.
- Required response: the next cycle o_valid=0, o_inflight=0, o_data_bus=0; neither token ever appears.
REQ-034 SHALL cover reset during a stall.
- Stimulus: rst=1 while i_en=0.
- Required response: state still clears; the first token accepted after reset emerges with correct sum 2 cycles later.
